// File: rtl/hb3_pkg.sv
// Shared HB3 definitions: ramp sequencer state encoding and the driver speed width.
package hb3_pkg;

  localparam int unsigned SPEED_W = 8;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RAMP  = 2'd1,
    BRAKE = 2'd2,
    DEAD  = 2'd3
  } hb3_state_t;

endpackage

// File: rtl/hb3_ramp_if.sv
// Target-command handshake into the ramp sequencer.
interface hb3_ramp_if;
  import hb3_pkg::*;

  logic               cmd_valid;
  logic               cmd_ready;
  logic [SPEED_W-1:0] cmd_speed;
  logic               cmd_dir;

  modport master (output cmd_valid, output cmd_speed, output cmd_dir, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_speed, input cmd_dir, output cmd_ready);

endinterface

// File: rtl/hb3_tick_gen.sv
// Free-running prescaler; tick is high while the count sits at STEP_DIV-1.
module hb3_tick_gen #(
  parameter int unsigned STEP_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = (cnt == LAST) ? '0 : cnt + CW'(1);
  end

  // tick is registered from the next count so it lines up with cnt == LAST
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt  <= '0;
      tick <= (LAST == '0);
    end else begin
      cnt  <= cnt_d;
      tick <= (cnt_d == LAST);
    end
  end

endmodule

// File: rtl/hb3_ramp.sv
// Speed/direction ramp sequencer feeding the HB3 PWM driver; reversals always pass
// through zero speed and a dead time, estop forces zero immediately.
module hb3_ramp
  import hb3_pkg::*;
#(
  parameter int unsigned STEP_DIV  = 1000,
  parameter int unsigned STEP      = 1,
  parameter int unsigned DEAD_CLKS = 16
) (
  input  logic               clk,
  input  logic               rst,
  hb3_ramp_if.slave          cmd,
  input  logic               estop,
  output logic [SPEED_W-1:0] speed,
  output logic               direction_control,
  output logic               busy,
  output logic               at_target
);

  localparam int unsigned DW = (DEAD_CLKS > 0) ? $clog2(DEAD_CLKS + 1) : 1;
  localparam logic [DW-1:0] DEAD_INIT = DW'(DEAD_CLKS);

  hb3_state_t         state_q, state_d;
  logic [SPEED_W-1:0] tgt_speed_q, tgt_speed_d;
  logic               tgt_dir_q, tgt_dir_d;
  logic [SPEED_W-1:0] speed_d;
  logic               dir_d;
  logic [DW-1:0]      dead_q, dead_d;
  logic               tick;
  logic               accept;

  logic [SPEED_W:0]   sum9, diff9;
  logic [SPEED_W-1:0] up_val, down_val, toward_val, brake_val;

  hb3_tick_gen #(.STEP_DIV(STEP_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign cmd.cmd_ready = (state_q != DEAD) && !estop;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign busy          = (state_q != HOLD);
  assign at_target     = (state_q == HOLD) && (speed == tgt_speed_q) &&
                         (direction_control == tgt_dir_q) && !estop;

  // Saturating one-step moves; 9-bit intermediates keep the clamps wrap-free
  always_comb begin
    sum9       = {1'b0, speed} + (SPEED_W+1)'(STEP);
    diff9      = {1'b0, speed} - (SPEED_W+1)'(STEP);
    up_val     = (sum9 > {1'b0, tgt_speed_q}) ? tgt_speed_q : sum9[SPEED_W-1:0];
    down_val   = (diff9[SPEED_W] || (diff9[SPEED_W-1:0] < tgt_speed_q)) ?
                 tgt_speed_q : diff9[SPEED_W-1:0];
    brake_val  = diff9[SPEED_W] ? '0 : diff9[SPEED_W-1:0];
    toward_val = (speed < tgt_speed_q) ? up_val : down_val;
  end

  always_comb begin
    state_d     = state_q;
    tgt_speed_d = tgt_speed_q;
    tgt_dir_d   = tgt_dir_q;
    speed_d     = speed;
    dir_d       = direction_control;
    dead_d      = dead_q;

    if (accept) begin
      tgt_speed_d = cmd.cmd_speed;
      tgt_dir_d   = cmd.cmd_dir;
    end

    if (estop) begin
      state_d = DEAD;
      speed_d = '0;
      dead_d  = DEAD_INIT;
    end else begin
      unique case (state_q)
        HOLD: begin
          // leaving HOLD on a tick also takes the first step in that same cycle
          if (tgt_dir_q != direction_control) begin
            if (speed == '0) begin
              state_d = DEAD;
              dead_d  = DEAD_INIT;
            end else if (tick) begin
              speed_d = brake_val;
              if (brake_val == '0) begin
                state_d = DEAD;
                dead_d  = DEAD_INIT;
              end else begin
                state_d = BRAKE;
              end
            end else begin
              state_d = BRAKE;
            end
          end else if (speed != tgt_speed_q) begin
            if (tick) begin
              speed_d = toward_val;
              state_d = (toward_val == tgt_speed_q) ? HOLD : RAMP;
            end else begin
              state_d = RAMP;
            end
          end
        end
        RAMP: begin
          if (tgt_dir_q != direction_control) begin
            state_d = BRAKE;
          end else if (speed == tgt_speed_q) begin
            state_d = HOLD;
          end else if (tick) begin
            speed_d = toward_val;
            if (toward_val == tgt_speed_q) state_d = HOLD;
          end
        end
        BRAKE: begin
          if (speed == '0) begin
            state_d = DEAD;
            dead_d  = DEAD_INIT;
          end else if (tick) begin
            speed_d = brake_val;
            if (brake_val == '0) begin
              state_d = DEAD;
              dead_d  = DEAD_INIT;
            end
          end
        end
        DEAD: begin
          speed_d = '0;
          if (dead_q == '0) begin
            dir_d   = tgt_dir_q;
            state_d = HOLD;
          end else begin
            dead_d = dead_q - DW'(1);
          end
        end
        default: state_d = HOLD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q           <= HOLD;
      tgt_speed_q       <= '0;
      tgt_dir_q         <= 1'b0;
      speed             <= '0;
      direction_control <= 1'b0;
      dead_q            <= '0;
    end else begin
      state_q           <= state_d;
      tgt_speed_q       <= tgt_speed_d;
      tgt_dir_q         <= tgt_dir_d;
      speed             <= speed_d;
      direction_control <= dir_d;
      dead_q            <= dead_d;
    end
  end

endmodule

// File: tb/tb_hb3_ramp.sv
// Scoreboard bench for hb3_ramp: expected {dir,speed} steps are queued by stimulus
// and popped by a monitor whenever the applied speed or direction changes.
module tb_hb3_ramp;

  logic       clk;
  logic       rst;
  logic       estop;
  logic [7:0] speed;
  logic       direction_control;
  logic       busy;
  logic       at_target;

  hb3_ramp_if cmd_if ();

  hb3_ramp #(.STEP_DIV(4), .STEP(16), .DEAD_CLKS(3)) dut (
    .clk               (clk),
    .rst               (rst),
    .cmd               (cmd_if.slave),
    .estop             (estop),
    .speed             (speed),
    .direction_control (direction_control),
    .busy              (busy),
    .at_target         (at_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic mon_en = 1'b0;
  logic [8:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic push(input logic dir, input logic [7:0] spd);
    exp_q.push_back({dir, spd});
  endtask

  task automatic wait_speed(input logic [7:0] v, input string name, output int at);
    int n;
    n = 0;
    checks++;
    while (speed !== v && n < 200) begin
      step();
      n++;
    end
    if (speed !== v) begin
      errors++;
      $display("FAIL %s timeout speed=%0h want=%0h", name, speed, v);
    end
    at = cyc;
  endtask

  task automatic send_cmd(input logic [7:0] spd, input logic dir, input string name);
    int n;
    n = 0;
    while (cmd_if.cmd_ready !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk({name, "_ready"}, 32'(cmd_if.cmd_ready), 32'd1);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_speed = spd;
    cmd_if.cmd_dir   = dir;
    step();
    cmd_if.cmd_valid = 1'b0;
  endtask

  // Monitor: every change of the applied outputs must match the next queued entry
  initial begin
    logic [8:0] prev;
    logic [8:0] cur;
    logic [8:0] want;
    prev = '0;
    forever begin
      @(posedge clk);
      #1;
      cur = {direction_control, speed};
      if (mon_en && cur !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL monitor unexpected dir=%0b speed=%0h", cur[8], cur[7:0]);
        end else begin
          want = exp_q.pop_front();
          if (cur !== want) begin
            errors++;
            $display("FAIL monitor step got dir=%0b speed=%0h want dir=%0b speed=%0h",
                     cur[8], cur[7:0], want[8], want[7:0]);
          end
        end
      end
      prev = cur;
    end
  end

  initial begin
    int t0, t1, t2, tx;
    rst              = 1'b0;
    estop            = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_speed = '0;
    cmd_if.cmd_dir   = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();

    chk("reset_speed", 32'(speed), 32'h0);
    chk("reset_dir", 32'(direction_control), 32'h0);
    chk("reset_ready", 32'(cmd_if.cmd_ready), 32'h1);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_at_target", 32'(at_target), 32'h1);
    mon_en = 1'b1;

    // Ramp up to 0x40
    for (int i = 1; i <= 4; i++) push(1'b0, 8'(i * 16));
    send_cmd(8'h40, 1'b0, "up");
    wait_speed(8'h10, "up_10", t0);
    chk("up_busy", 32'(busy), 32'h1);
    chk("up_not_at_target", 32'(at_target), 32'h0);
    wait_speed(8'h20, "up_20", t1);
    wait_speed(8'h30, "up_30", t2);
    chk("up_interval_a", 32'(t1 - t0), 32'd4);
    chk("up_interval_b", 32'(t2 - t1), 32'd4);
    wait_speed(8'h40, "up_40", tx);
    chk("up_at_target", 32'(at_target), 32'h1);
    chk("up_idle", 32'(busy), 32'h0);

    // No overshoot in either direction
    push(1'b0, 8'h45);
    send_cmd(8'h45, 1'b0, "ovr_up");
    wait_speed(8'h45, "ovr_45", tx);
    push(1'b0, 8'h35); push(1'b0, 8'h25); push(1'b0, 8'h15);
    push(1'b0, 8'h05); push(1'b0, 8'h03);
    send_cmd(8'h03, 1'b0, "ovr_dn");
    wait_speed(8'h03, "ovr_03", tx);
    chk("ovr_at_target", 32'(at_target), 32'h1);
    push(1'b0, 8'h13); push(1'b0, 8'h23); push(1'b0, 8'h33); push(1'b0, 8'h40);
    send_cmd(8'h40, 1'b0, "back40");
    wait_speed(8'h40, "back_40", tx);

    // Reversal through zero and dead time
    push(1'b0, 8'h30); push(1'b0, 8'h20); push(1'b0, 8'h10); push(1'b0, 8'h00);
    push(1'b1, 8'h00); push(1'b1, 8'h10); push(1'b1, 8'h20);
    send_cmd(8'h20, 1'b1, "rev");
    wait_speed(8'h00, "rev_zero", tx);
    for (int i = 0; i < 4; i++) begin
      chk("rev_dead_ready", 32'(cmd_if.cmd_ready), 32'h0);
      chk("rev_dead_dir", 32'(direction_control), 32'h0);
      step();
    end
    chk("rev_dir_flip", 32'(direction_control), 32'h1);
    wait_speed(8'h20, "rev_20", tx);
    chk("rev_at_target", 32'(at_target), 32'h1);
    push(1'b1, 8'h30); push(1'b1, 8'h40);
    send_cmd(8'h40, 1'b1, "rev40");
    wait_speed(8'h40, "rev_40", tx);

    // Estop pulse at 0x40 / dir1
    push(1'b1, 8'h00);
    for (int i = 1; i <= 4; i++) push(1'b1, 8'(i * 16));
    estop = 1'b1;
    step();
    chk("estop_speed", 32'(speed), 32'h0);
    chk("estop_dir", 32'(direction_control), 32'h1);
    chk("estop_ready", 32'(cmd_if.cmd_ready), 32'h0);
    chk("estop_at_target", 32'(at_target), 32'h0);
    estop = 1'b0;
    chk("estop_dead_ready", 32'(cmd_if.cmd_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("estop_dead_hold", 32'(cmd_if.cmd_ready), 32'h0);
    end
    step();
    chk("estop_released_busy", 32'(busy), 32'h0);
    wait_speed(8'h40, "estop_40", tx);
    chk("estop_dir_kept", 32'(direction_control), 32'h1);

    // Mid-ramp reset at 0x30 after a second estop
    push(1'b1, 8'h00); push(1'b1, 8'h10); push(1'b1, 8'h20); push(1'b1, 8'h30);
    estop = 1'b1;
    step();
    estop = 1'b0;
    wait_speed(8'h30, "rst_30", tx);
    push(1'b0, 8'h00);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("rst_speed", 32'(speed), 32'h0);
    chk("rst_dir", 32'(direction_control), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_targets_zero", 32'(at_target), 32'h1);
    repeat (8) step();
    chk("rst_speed_stays", 32'(speed), 32'h0);

    // Retarget mid-ramp, then saturate at 0xFF
    for (int i = 1; i <= 5; i++) push(1'b0, 8'(i * 16));
    send_cmd(8'hFF, 1'b0, "sat");
    wait_speed(8'h50, "retgt_50", tx);
    push(1'b0, 8'h60); push(1'b0, 8'h70); push(1'b0, 8'h80);
    send_cmd(8'h80, 1'b0, "retgt");
    wait_speed(8'h80, "retgt_80", tx);
    repeat (6) step();
    chk("retgt_stop_80", 32'(speed), 32'h80);
    chk("retgt_at_target", 32'(at_target), 32'h1);
    for (int i = 9; i <= 15; i++) push(1'b0, 8'(i * 16));
    push(1'b0, 8'hFF);
    send_cmd(8'hFF, 1'b0, "sat2");
    wait_speed(8'hFF, "sat_ff", tx);
    repeat (8) step();
    chk("sat_hold_ff", 32'(speed), 32'hFF);
    chk("sat_at_target", 32'(at_target), 32'h1);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hb3_ramp.md
# hb3_ramp

Speed and direction command sequencer that sits directly upstream of the HB3 PWM driver and drives its `speed` and `direction_control` inputs. It moves the applied speed toward a commanded target in fixed steps at a fixed tick rate. A direction reversal always ramps down to zero, holds a dead time, flips direction, then ramps up, so the driver never sees a direction change at non-zero speed. An emergency-stop input forces zero speed immediately.

## Interface
- `STEP_DIV`, 1000: clocks per ramp tick (≥1).
- `STEP`, 1: speed change per tick (1..255).
- `DEAD_CLKS`, 16: clocks held at zero speed before a direction flip (≥0).

- `clk` in 1: system clock.
- `rst` in 1: **synchronous, active-low** reset (0 = reset).
- `cmd_valid` in 1: new target offered.
- `cmd_ready` out 1: target accepted when `cmd_valid & cmd_ready`.
- `cmd_speed` in 8: target speed magnitude.
- `cmd_dir` in 1: target direction.
- `estop` in 1: emergency stop, level-sensitive, highest priority after reset.
- `speed` out 8: applied speed, to driver `speed`.
- `direction_control` out 1: applied direction, to driver `direction_control`.
- `busy` out 1: state ≠ HOLD.
- `at_target` out 1: state = HOLD, `speed` = target, direction = target direction, `estop` low.

## Operation
- Registers: `tgt_speed`, `tgt_dir`, `speed`, `direction_control`, state, prescaler, dead counter.
- Reset values: `speed`=0, `direction_control`=0, `tgt_speed`=0, `tgt_dir`=0, state HOLD, prescaler 0, dead counter 0. Resulting outputs: `cmd_ready`=1, `busy`=0, `at_target`=1.
- Prescaler: free-running counter over 0..STEP_DIV-1. `tick` is high in the cycle the count equals STEP_DIV-1. The prescaler is not reset by commands.
- `cmd_ready` = state ≠ DEAD and `estop` low. An accepted command overwrites the targets in any other state, including mid-ramp.
- **HOLD**
  - `tgt_dir` ≠ `direction_control` and `speed` > 0 → BRAKE.
  - `tgt_dir` ≠ `direction_control` and `speed` = 0 → DEAD; load dead counter with DEAD_CLKS.
  - `speed` ≠ `tgt_speed` → RAMP.
- **RAMP**
  - On `tick`, step toward `tgt_speed` by STEP, clamped to the target (no overshoot).
  - On reaching the target → HOLD.
  - If `tgt_dir` changes → BRAKE.
- **BRAKE**
  - On `tick`, `speed` = max(`speed`-STEP, 0).
  - On reaching 0 → DEAD; load dead counter.
- **DEAD**
  - `speed` stays 0; the dead counter decrements each clock.
  - In the cycle the counter is 0: `direction_control` ← `tgt_dir`, next state HOLD.
  - With DEAD_CLKS=0, exactly one cycle is spent in DEAD.
- **estop high**
  - Next edge: `speed`=0, state DEAD, dead counter reloaded every cycle.
  - `direction_control` does not change while `estop` is high.
  - After release, normal DEAD countdown, then HOLD, then ramp to the stored target.
- Arithmetic: 9-bit intermediate for add/subtract; clamp to 0..255; no wrap.
- A target equal to current speed with matching direction is a no-op; state stays HOLD.

## Timing
- All outputs are registered except `cmd_ready`, `busy` and `at_target`, which are decoded from registers and `estop`.
- Command accepted in cycle N: targets visible in N+1. State change out of HOLD in N+1. First speed step at the first `tick` at or after N+1, with `speed` updating on the edge ending that tick cycle.
- `direction_control` changes only on an edge where registered `speed` = 0, and never in the same cycle as a non-zero `speed`.
- Reset asserted mid-operation: all registers take reset values on the next edge, regardless of state or `estop`.
- Reversal total latency: ceil(`speed`/STEP) ticks down + DEAD_CLKS+1 clocks + ceil(`tgt_speed`/STEP) ticks up.

## Structure
- Shared package `hb3_pkg`: state encoding constants (HOLD, RAMP, BRAKE, DEAD) and the 8-bit speed width constant, also used by the driver.
- One sub-module: `hb3_tick_gen` (parameterised prescaler, outputs `tick`).
- The FSM, saturating arithmetic and handshake stay in `hb3_ramp`.

## Test plan
All scenarios use STEP_DIV=4, STEP=16, DEAD_CLKS=3.
- **Ramp up:** reset release, then command 0x40/dir0 → `speed` 0x10, 0x20, 0x30, 0x40 at 4-clock intervals; `busy` 1 during the ramp; `at_target` 1 after 0x40.
- **No overshoot:** command 0x45 → …0x40, 0x45. Then command 0x03 → 0x35, 0x25, 0x15, 0x05, 0x03.
- **Reversal:** at 0x40/dir0, command 0x20/dir1.
  - → 0x30, 0x20, 0x10, 0x00.
  - DEAD for 4 clocks with `cmd_ready` 0.
  - `direction_control` 1 only after `speed` has been 0 for 4 clocks.
  - Then 0x10, 0x20, `at_target` 1.
- **Estop:** `estop` pulsed high at 0x40 → `speed` 0x00 on the next edge and `direction_control` unchanged. After release, 4 clocks in DEAD, then 0x10…0x40.
- **Mid-ramp reset:** `rst` low for 1 cycle at `speed` 0x30 → next edge `speed` 0, `direction_control` 0, `busy` 0, targets 0.
- **Saturation and retarget:** command 0xFF → …0xF0, 0xFF. A command of 0x80 accepted mid-ramp at 0x50 → ramp ends at 0x80.
